// File: rtl/weight_feed_skew.sv
// Weight feeder with a ready/valid shadow buffer and an optional diagonal skew.
// The shadow buffer takes the next tile while the active word streams out one
// element per channel per tick. When skew is enabled, channel c lags channel 0
// by c ticks.
module weight_feed_skew #(
   parameter int NUM_CH    = 4,
   parameter int DATA_W    = 8,
   parameter int ELEMS     = 4,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit SKEW_EN   = 1'b1
) (
   input  logic                           clk,
   input  logic                           rstn,
   input  logic                           load_valid,
   output logic                           load_ready,
   input  logic [NUM_CH*ELEMS*DATA_W-1:0] load_data,
   input  logic                           start,
   input  logic                           stall,
   output logic                           busy,
   output logic                           done,
   output logic [NUM_CH*DATA_W-1:0]       dout,
   output logic [NUM_CH-1:0]              dout_valid
);

   localparam int W     = ELEMS * DATA_W;
   localparam int LW    = NUM_CH * W;
   localparam int L     = ELEMS + (NUM_CH - 1) * int'(SKEW_EN);
   localparam int CNT_W = (L + 1 > 1) ? $clog2(L + 1) : 1;

   typedef enum logic {IDLE, STREAM} state_t;

   state_t                   state, state_d;
   logic                     shadow_full;
   logic [LW-1:0]            shadow;
   logic [LW-1:0]            active;
   logic [CNT_W-1:0]         k;
   logic                     start_pass, tick, last_tick;
   logic [NUM_CH*DATA_W-1:0] dout_nxt;
   logic [NUM_CH-1:0]        vld_nxt;

   assign load_ready = !shadow_full;
   assign busy       = (state == STREAM);

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
      if (!rstn) state <= IDLE;
      else       state <= state_d;
   end

   // Next-state logic: decide whether a pass launches, ticks or finishes this cycle.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
      state_d    = state;
      start_pass = 1'b0;
      tick       = 1'b0;
      last_tick  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start && shadow_full) begin
               state_d    = STREAM;
               start_pass = 1'b1;
            end
         end
         STREAM: begin
            if (!stall) begin
               tick = 1'b1;
               if (k == CNT_W'(L - 1)) begin
                  state_d   = IDLE;
                  last_tick = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Element selection for the current tick: channel c shows element k - c*SKEW_EN when that index is in range.
   always_comb begin
      int e;
      int lo;
      e        = 0;
      lo       = 0;
      dout_nxt = '0;
      vld_nxt  = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         e = int'(k) - c * int'(SKEW_EN);
         if (e >= 0 && e < ELEMS) begin
            lo          = MSB_FIRST ? (ELEMS - 1 - e) * DATA_W : e * DATA_W;
            vld_nxt[c]  = 1'b1;
            dout_nxt[c*DATA_W +: DATA_W] = active[c*W + lo +: DATA_W];
         end
      end
   end

   // Shadow payload: captured on an accepted load.
   always_ff @(posedge clk) begin
      // NOTE: the payload registers have no reset. The shadow_full flag alone decides whether their contents mean anything.
      if (load_valid && !shadow_full) shadow <= load_data;
   end

   // Control and output registers: shadow flag, active word, tick counter, dout and done.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         shadow_full <= 1'b0;
         active      <= '0;
         k           <= '0;
         dout        <= '0;
         dout_valid  <= '0;
         done        <= 1'b0;
      end else begin
         if (load_valid && !shadow_full) shadow_full <= 1'b1;
         else if (start_pass)            shadow_full <= 1'b0;

         if (start_pass) begin
            active <= shadow;
            k      <= '0;
         end else if (tick) begin
            k <= k + CNT_W'(1);
         end

         done <= last_tick;

         if (state == IDLE) begin
            dout       <= '0;
            dout_valid <= '0;
         end else if (tick) begin
            dout       <= dout_nxt;
            dout_valid <= vld_nxt;
         end
      end
   end

endmodule

// File: tb/tb_weight_feed_skew.sv
// Bench for weight_feed_skew. It runs three parameter sets side by side: the
// defaults, an unskewed LSB-first set, and an 8x2x16 set. Each set drives a
// directed script followed by random traffic. On every clock the reference
// model predicts the outputs after the next edge and pushes them into a queue.
// A separate monitor pops and compares once per cycle.
module tb_weight_feed_skew;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   bit fin [3];

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   for (genvar g = 0; g < 3; g++) begin : gen_cfg
      localparam int NC = (g == 2) ? 8 : 4;
      localparam int DW = (g == 2) ? 16 : 8;
      localparam int EL = (g == 2) ? 2 : 4;
      localparam bit MF = (g == 1) ? 1'b0 : 1'b1;
      localparam bit SK = (g == 1) ? 1'b0 : 1'b1;
      localparam int W  = EL * DW;
      localparam int LW = NC * W;
      localparam int L  = EL + (NC - 1) * int'(SK);

      typedef struct {
         logic [NC*DW-1:0] dout;
         logic [NC-1:0]    vld;
         logic             done;
         logic             busy;
         logic             lrdy;
      } exp_t;

      logic             rstn, load_valid, load_ready, start, stall, busy, done;
      logic [LW-1:0]    load_data;
      logic [NC*DW-1:0] dout;
      logic [NC-1:0]    dout_valid;

      weight_feed_skew #(
         .NUM_CH(NC), .DATA_W(DW), .ELEMS(EL), .MSB_FIRST(MF), .SKEW_EN(SK)
      ) dut (
         .clk(clk), .rstn(rstn), .load_valid(load_valid), .load_ready(load_ready),
         .load_data(load_data), .start(start), .stall(stall), .busy(busy),
         .done(done), .dout(dout), .dout_valid(dout_valid)
      );

      exp_t exp_q[$];

      // Reference model state, kept as the pass as a whole: mode, shadow contents, tick index.
      bit               m_busy = 1'b0;
      bit               m_full = 1'b0;
      int               m_k    = 0;
      logic [LW-1:0]    m_shadow = '0;
      logic [LW-1:0]    m_active = '0;
      logic [NC*DW-1:0] m_dout = '0;
      logic [NC-1:0]    m_vld  = '0;
      bit               m_done = 1'b0;

      function automatic logic [LW-1:0] rnd_word();
         logic [LW-1:0] w;
         w = '0;
         for (int i = 0; i < LW / 32; i++) w = (w << 32) | LW'($urandom);
         return w;
      endfunction

      // Predicts the outputs after the coming edge from this cycle's inputs.
      task automatic model_step();
         bit accept;
         int e;
         logic [LW-1:0] w;
         exp_t x;
         accept = load_valid && !m_full;
         if (!rstn) begin
            m_busy = 1'b0; m_full = 1'b0; m_k = 0;
            m_dout = '0; m_vld = '0; m_done = 1'b0;
         end else begin
            m_done = 1'b0;
            if (!m_busy) begin
               m_dout = '0; m_vld = '0;
               if (start && m_full) begin
                  m_busy = 1'b1; m_active = m_shadow; m_full = 1'b0; m_k = 0;
               end
            end else if (!stall) begin
               for (int c = 0; c < NC; c++) begin
                  e = m_k - c * int'(SK);
                  if (e >= 0 && e < EL) begin
                     w = m_active >> (c * W + (MF ? (EL - 1 - e) : e) * DW);
                     m_dout[c*DW +: DW] = w[DW-1:0];
                     m_vld[c] = 1'b1;
                  end else begin
                     m_dout[c*DW +: DW] = '0;
                     m_vld[c] = 1'b0;
                  end
               end
               if (m_k == L - 1) begin
                  m_busy = 1'b0; m_done = 1'b1;
               end
               m_k++;
            end
            if (accept) begin
               m_shadow = load_data; m_full = 1'b1;
            end
         end
         x.dout = m_dout; x.vld = m_vld; x.done = m_done;
         x.busy = m_busy; x.lrdy = !m_full;
         exp_q.push_back(x);
      endtask

      task automatic drive(input bit r, input bit lv, input bit st, input bit sl, input logic [LW-1:0] d);
         rstn = r; load_valid = lv; start = st; stall = sl; load_data = d;
         model_step();
         @(negedge clk);
      endtask

      // Stimulus: directed scenarios first, then random traffic.
      initial begin
         logic [LW-1:0] w1;
         w1 = (g < 2) ? LW'(128'hDDEEFF00_99AABBCC_55667788_11223344) : rnd_word();
         repeat (2) drive(0, 0, 0, 0, '0);
         // Start with an empty shadow, then a load and a start together while the shadow is empty.
         drive(1, 0, 1, 0, '0);
         drive(1, 0, 0, 0, '0);
         drive(1, 1, 1, 0, w1);
         repeat (2) drive(1, 0, 0, 0, '0);
         // Single pass on the reference words.
         drive(1, 0, 1, 0, '0);
         repeat (L + 2) drive(1, 0, 0, 0, '0);
         // Loads during a pass, a held-off third load, and a restart in the done cycle.
         drive(1, 1, 0, 0, rnd_word());
         repeat (2 * L + 6) drive(1, 1, 1, 0, rnd_word());
         repeat (2 * L + 4) drive(1, 0, 0, 0, '0);
         // Two-cycle stall at tick 2.
         drive(1, 1, 0, 0, rnd_word());
         drive(1, 0, 1, 0, '0);
         repeat (2) drive(1, 0, 0, 0, '0);
         repeat (2) drive(1, 0, 0, 1, '0);
         repeat (L + 2) drive(1, 0, 0, 0, '0);
         // Reset at tick 3 of a pass.
         drive(1, 1, 0, 0, rnd_word());
         drive(1, 0, 1, 0, '0);
         repeat (3) drive(1, 0, 0, 0, '0);
         drive(0, 1, 1, 0, rnd_word());
         repeat (3) drive(1, 0, 0, 0, '0);
         // Random traffic.
         for (int i = 0; i < 400; i++)
            drive($urandom_range(0, 49) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, rnd_word());
         fin[g] = 1'b1;
      end

      // Monitor: sample 2 time units after each rising edge and compare with the oldest prediction.
      initial begin
         exp_t x;
         forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
               x = exp_q.pop_front();
               n_vec++;
               check($sformatf("cfg%0d dout", g),       256'(dout),       256'(x.dout));
               check($sformatf("cfg%0d dout_valid", g), 256'(dout_valid), 256'(x.vld));
               check($sformatf("cfg%0d done", g),       256'(done),       256'(x.done));
               check($sformatf("cfg%0d busy", g),       256'(busy),       256'(x.busy));
               check($sformatf("cfg%0d load_ready", g), 256'(load_ready), 256'(x.lrdy));
            end
         end
      end
   end

   initial begin
      int cyc;
      cyc = 0;
      while (!(fin[0] && fin[1] && fin[2]) && cyc < 20000) begin
         @(posedge clk);
         cyc++;
      end
      if (!(fin[0] && fin[1] && fin[2])) begin
         n_err++;
         $display("FAIL timeout: stimulus finished %0d%0d%0d expected 111", fin[0], fin[1], fin[2]);
      end
      repeat (3) @(posedge clk);
      #3;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
